// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
//   Shared constants and helpers for the Hermes interrupt controller.
//   - reg_addr_e : register map selected by address[1:0]
//   - VEC_NONE   : VECTOR read value when nothing is pending and enabled
//   - MAX_WIDTH  : widest supported source count (register width)
//   - vec_encode : lowest-index-wins priority encoder producing VECTOR
package irq_ctrl_pkg;

  localparam int MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_MASK   = 2'd1,
    REG_MODE   = 2'd2,
    REG_VECTOR = 2'd3
  } reg_addr_e;

  localparam logic [7:0] VEC_NONE = 8'h80;

  // Register state held by the controller, grouped so it can be observed
  // as one unit.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] pending;
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] mode;
  } irq_regs_t;

  // Bit 0 is the highest priority. Scanning downwards lets the lowest set
  // index overwrite any higher one.
  function automatic logic [7:0] vec_encode(input logic [MAX_WIDTH-1:0] act);
    logic [7:0] v;
    v = VEC_NONE;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (act[i]) v = {5'b00000, 3'(i)};
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync
//   Per-source front end: two-flop synchroniser for an asynchronous
//   active-low IRQ line plus a previous-value flop for edge detection.
//   All flops update on the falling edge of phi2 and reset to 1 (inactive),
//   so a line already held low when reset releases looks like a new edge.
// Ports
//   phi2    in  CPU clock, state changes on the falling edge
//   reset_n in  asynchronous active-low reset
//   src_n   in  raw active-low IRQ line
//   sync_n  out synchronised level (active low)
//   fall    out one-cycle strobe: synchronised 1->0 transition seen
module irq_sync (
  input  logic phi2,
  input  logic reset_n,
  input  logic src_n,
  output logic sync_n,
  output logic fall
);

  logic sync1_n;
  logic sync2_n;
  logic prev_n;

  always_ff @(negedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_n <= 1'b1;
      sync2_n <= 1'b1;
      prev_n  <= 1'b1;
    end else begin
      sync1_n <= src_n;
      sync2_n <= sync1_n;
      prev_n  <= sync2_n;
    end
  end

  assign sync_n = sync2_n;
  assign fall   = prev_n & ~sync2_n;

endmodule

// File: rtl/irq_controller.sv
// irq_controller
//   Maskable, prioritised interrupt controller for the Hermes system
//   controller. Synchronises each peripheral IRQ, latches edge-mode events,
//   applies a CPU-writable mask and drives a registered irq_n to the CPU.
//   Register map (address[1:0]):
//     0 STATUS  read pending; write-1-to-clear edge-mode bits
//     1 MASK    read/write, 1 = enabled
//     2 MODE    read/write, 1 = falling-edge, 0 = level
//     3 VECTOR  read-only, lowest pending&enabled index, 0x80 when none
//   Bits at or above WIDTH read 0 and ignore writes.
// Ports
//   phi2          in  CPU clock; all state updates on its falling edge
//   reset_n       in  asynchronous active-low reset
//   cs_n          in  register select from the address decoder
//   read_write    in  1 = read, 0 = write
//   reg_addr      in  register select (address[1:0])
//   d_in          in  write data
//   d_out         out read data (combinational)
//   d_oe          out drive enable for d_out
//   irq_sources_n in  active-low device IRQs, bit 0 highest priority
//   irq_n         out registered active-low IRQ to the CPU
//
// Bus semantics: a write is a bus cycle with cs_n=0 and read_write=0; the
// data is captured on the falling edge of phi2 that ends the cycle. A read
// is cs_n=0 and read_write=1; d_out is valid combinationally and d_oe is
// asserted only while phi2 is high. Reads never change any state.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int WIDTH = 6  // legal range 1..MAX_WIDTH
) (
  input  logic             phi2,
  input  logic             reset_n,
  input  logic             cs_n,
  input  logic             read_write,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       d_in,
  output logic [7:0]       d_out,
  output logic             d_oe,
  input  logic [WIDTH-1:0] irq_sources_n,
  output logic             irq_n
);

  // Registers are kept at full bus width; bits at or above WIDTH are forced
  // to zero so they read back 0 and synthesis trims the constant flops.
  localparam logic [MAX_WIDTH-1:0] SRC_MASK = MAX_WIDTH'((1 << WIDTH) - 1);

  logic [MAX_WIDTH-1:0] sync_n_vec;
  logic [MAX_WIDTH-1:0] fall_vec;

  irq_regs_t regs_q;
  irq_regs_t regs_next;

  logic                 wr_en;
  logic [MAX_WIDTH-1:0] clr_vec;

  // ---------------------------------------------------------------------
  // Source front ends
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < MAX_WIDTH; i++) begin : g_src
    if (i < WIDTH) begin : g_used
      irq_sync u_sync (
        .phi2    (phi2),
        .reset_n (reset_n),
        .src_n   (irq_sources_n[i]),
        .sync_n  (sync_n_vec[i]),
        .fall    (fall_vec[i])
      );
    end else begin : g_unused
      assign sync_n_vec[i] = 1'b1;
      assign fall_vec[i]   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  assign wr_en = ~cs_n & ~read_write;

  always_comb begin
    regs_next = regs_q;
    clr_vec   = '0;

    if (wr_en && (reg_addr == REG_MASK)) regs_next.mask = d_in & SRC_MASK;
    if (wr_en && (reg_addr == REG_MODE)) regs_next.mode = d_in & SRC_MASK;
    if (wr_en && (reg_addr == REG_STATUS)) clr_vec = d_in;

    // The new MODE applies on the edge it is written, so a bit switched from
    // level to edge simply keeps its current pending value and latches from
    // there. In edge mode a new fall beats a simultaneous clear.
    regs_next.pending = ((regs_next.mode & (fall_vec | (regs_q.pending & ~clr_vec))) |
                         (~regs_next.mode & ~sync_n_vec)) & SRC_MASK;
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(negedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
      irq_n  <= 1'b1;
    end else begin
      regs_q <= regs_next;
      // Built from the next values so a mask write or a clear takes effect
      // on the same edge that performs it.
      irq_n  <= ~|(regs_next.pending & regs_next.mask);
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  always_comb begin
    d_out = 8'h00;
    case (reg_addr)
      REG_STATUS: d_out = regs_q.pending;
      REG_MASK:   d_out = regs_q.mask;
      REG_MODE:   d_out = regs_q.mode;
      REG_VECTOR: d_out = vec_encode(regs_q.pending & regs_q.mask);
      default:    d_out = 8'h00;
    endcase
  end

  assign d_oe = phi2 & ~cs_n & read_write;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
//   Directed bench for irq_controller (WIDTH = 6). Inputs change one time
//   unit after the active (falling) phi2 edge; outputs are sampled in the
//   same quiet window.
module tb_irq_controller;

  logic       phi2;
  logic       reset_n;
  logic       cs_n;
  logic       read_write;
  logic [1:0] reg_addr;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic [5:0] irq_sources_n;
  logic       irq_n;

  int total = 0;
  int bad   = 0;

  irq_controller #(.WIDTH(6)) dut (
    .phi2          (phi2),
    .reset_n       (reset_n),
    .cs_n          (cs_n),
    .read_write    (read_write),
    .reg_addr      (reg_addr),
    .d_in          (d_in),
    .d_out         (d_out),
    .d_oe          (d_oe),
    .irq_sources_n (irq_sources_n),
    .irq_n         (irq_n)
  );

  // ---------------- clock ----------------
  initial begin
    phi2 = 1'b1;
    forever #10 phi2 = ~phi2;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge phi2);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs_n       = 1'b0;
    read_write = 1'b0;
    reg_addr   = a;
    d_in       = d;
    @(negedge phi2);
    #1;
    cs_n       = 1'b1;
    read_write = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    cs_n       = 1'b0;
    read_write = 1'b1;
    reg_addr   = a;
    #1;
    v    = d_out;
    cs_n = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {7'b0, irq_n}, {7'b0, exp});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n       = 1'b0;
    cs_n          = 1'b1;
    read_write    = 1'b1;
    reg_addr      = 2'd0;
    d_in          = 8'h00;
    irq_sources_n = 6'h3F;

    // Reset state
    tick(3);
    reset_n = 1'b1;
    check_irq("rst_irq_n", 1'b1);
    check_reg("rst_status", 2'd0, 8'h00);
    check_reg("rst_mask",   2'd1, 8'h00);
    check_reg("rst_mode",   2'd2, 8'h00);
    check_reg("rst_vector", 2'd3, 8'h80);
    check("rst_d_oe_idle", {7'b0, d_oe}, 8'h00);

    // d_oe only while phi2 high with a read selected
    @(posedge phi2);
    #1;
    cs_n = 1'b0;
    read_write = 1'b1;
    #1;
    check("d_oe_read_high", {7'b0, d_oe}, 8'h01);
    cs_n = 1'b1;
    #1;
    check("d_oe_deselect", {7'b0, d_oe}, 8'h00);
    tick(1);

    // Level mode latency: bits above WIDTH are dropped from the MASK write
    wr(2'd1, 8'hFF);
    check_reg("mask_trunc", 2'd1, 8'h3F);
    irq_sources_n[3] = 1'b0;
    tick(1);
    check_irq("lvl_n0", 1'b1);
    tick(1);
    check_irq("lvl_n1", 1'b1);
    tick(1);
    check_irq("lvl_n2", 1'b0);
    check_reg("lvl_vector", 2'd3, 8'h03);
    check_reg("lvl_status", 2'd0, 8'h08);
    irq_sources_n[3] = 1'b1;
    tick(2);
    check_irq("lvl_rel_n1", 1'b0);
    tick(1);
    check_irq("lvl_rel_n2", 1'b1);
    check_reg("lvl_rel_status", 2'd0, 8'h00);
    check_reg("lvl_rel_vector", 2'd3, 8'h80);

    // Edge mode: two-edge pulse on source 5 is latched and held
    wr(2'd2, 8'h3F);
    check_reg("mode_rb", 2'd2, 8'h3F);
    irq_sources_n[5] = 1'b0;
    tick(2);
    irq_sources_n[5] = 1'b1;
    check_reg("edge_pre_status", 2'd0, 8'h00);
    tick(1);
    check_reg("edge_set_status", 2'd0, 8'h20);
    check_irq("edge_set_irq", 1'b0);
    tick(3);
    check_reg("edge_hold_status", 2'd0, 8'h20);
    check_reg("edge_hold_vector", 2'd3, 8'h05);
    wr(2'd0, 8'h20);
    check_reg("edge_clr_status", 2'd0, 8'h00);
    check_irq("edge_clr_irq", 1'b1);

    // Priority and mask: sources 1 and 4 pending
    irq_sources_n[1] = 1'b0;
    irq_sources_n[4] = 1'b0;
    tick(3);
    irq_sources_n[1] = 1'b1;
    irq_sources_n[4] = 1'b1;
    check_reg("prio_status", 2'd0, 8'h12);
    check_reg("prio_vector", 2'd3, 8'h01);
    check_irq("prio_irq", 1'b0);
    wr(2'd1, 8'h3C);
    check_reg("prio_masked_vector", 2'd3, 8'h04);
    check_irq("prio_masked_irq", 1'b0);
    check_reg("prio_masked_status", 2'd0, 8'h12);
    wr(2'd1, 8'h3F);
    wr(2'd0, 8'h12);
    check_reg("prio_clr_status", 2'd0, 8'h00);
    check_irq("prio_clr_irq", 1'b1);

    // Set and clear on the same edge: set wins
    irq_sources_n[2] = 1'b0;
    tick(3);
    irq_sources_n[2] = 1'b1;
    check_reg("race_pre_status", 2'd0, 8'h04);
    tick(3);
    irq_sources_n[2] = 1'b0;
    tick(2);
    wr(2'd0, 8'h04);
    check_reg("race_status", 2'd0, 8'h04);
    check_irq("race_irq", 1'b0);
    irq_sources_n[2] = 1'b1;
    tick(3);
    wr(2'd0, 8'h04);
    check_reg("race_clr_status", 2'd0, 8'h00);
    check_irq("race_clr_irq", 1'b1);

    // Level-mode bit ignores STATUS writes
    wr(2'd2, 8'h3E);
    irq_sources_n[0] = 1'b0;
    tick(3);
    check_reg("lvl0_status", 2'd0, 8'h01);
    check_reg("lvl0_vector", 2'd3, 8'h00);
    wr(2'd0, 8'h01);
    check_reg("lvl0_noclr_status", 2'd0, 8'h01);
    check_irq("lvl0_irq", 1'b0);

    // Asynchronous reset mid-cycle with irq_n low; source 0 stays low
    #3;
    reset_n = 1'b0;
    #1;
    check_irq("arst_irq_n", 1'b1);
    check_reg("arst_status", 2'd0, 8'h00);
    #1;
    reset_n = 1'b1;
    check_reg("arst_mask", 2'd1, 8'h00);
    check_reg("arst_mode", 2'd2, 8'h00);
    tick(2);
    check_reg("arst_n1_status", 2'd0, 8'h00);
    tick(1);
    check_reg("arst_n2_status", 2'd0, 8'h01);
    check_irq("arst_masked_irq", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Maskable, prioritised interrupt controller between the six peripheral IRQ lines and the CPU `irq_n` input of the Hermes system controller. It synchronises each source, latches edge-mode events, applies a CPU-writable mask and presents a priority vector. It is a register-mapped peripheral on the Hermes peripheral data bus, selected by an address-decoder chip select. It replaces the purely combinational aggregation of `irq_*_n` lines.

## Interface
- `WIDTH`, 6: number of IRQ sources; legal range 1..8.
- `phi2`  in  1  CPU clock; all state updates on the falling edge (end of bus cycle).
- `reset_n`  in  1  asynchronous, active-low reset.
- `cs_n`  in  1  register select from the address decoder; already qualified by valid address.
- `read_write`  in  1  CPU RW; high = read, low = write.
- `reg_addr`  in  2  `address[1:0]`; selects the register.
- `d_in`  in  8  peripheral data bus, write path.
- `d_out`  out  8  read data.
- `d_oe`  out  1  drive enable for `d_out`; Hermes muxes it onto `d`.
- `irq_sources_n`  in  WIDTH  active-low device IRQs; bit 0 = highest priority.
- `irq_n`  out  1  active-low IRQ to the CPU; registered.

## Operation
- Registers. Bits above WIDTH read 0 and ignore writes.
  - 0 STATUS: read returns pending. Write-1-to-clear for edge-mode bits; ignored for level-mode bits.
  - 1 MASK: read/write; 1 = enabled.
  - 2 MODE: read/write; 1 = falling-edge, 0 = level.
  - 3 VECTOR: read-only. Bits[2:0] = index of the lowest-numbered pending & enabled source; bit 7 = 1 when none, with bits[2:0] = 0.
- Per source:
  - Two-flop synchroniser, reset to 1 (inactive).
  - A third flop holds the previous synchronised value for edge detection.
- Level mode: `pending[i]` = inverted synchronised level, re-evaluated every edge.
- Edge mode: `pending[i]` sets on a synchronised 1→0 transition and holds until cleared by a STATUS write.
  - A set and a clear on the same edge: set wins.
- Changing MODE from level to edge leaves the current pending bit as-is. It then behaves as edge-latched.
- `irq_n` is a flop loaded with `~|(pending_next & mask_next)`. Mask changes therefore take effect on the same edge as the write.
- Write: on the `phi2` falling edge when `cs_n`=0 and `read_write`=0, `d_in` is captured into the addressed register.
- Read: `d_out` is combinational from the registers and `reg_addr`; `d_oe` = `phi2 & ~cs_n & read_write`.
  - Reads have no side effects; reading VECTOR does not acknowledge.
- Reset: pending, MASK and MODE = 0; synchroniser and previous-value flops = 1; `irq_n` = 1; `d_oe` = 0; VECTOR reads 0x80.

## Timing
- A source first low at falling edge N:
  - sync1 low after N; sync2 low after N+1.
  - pending set and `irq_n` low after N+2, if enabled.
  - Latency: 3 falling edges.
- A source pulse must be low for at least 2 falling edges to be guaranteed captured. Shorter pulses may be missed.
- STATUS clear at edge M with the source idle: `irq_n` high after M.
- Level source released at edge N: `irq_n` high after N+2.
- Reset asserted mid-cycle:
  - All state clears immediately; `irq_n` = 1 asynchronously.
  - Any in-flight write is lost.
  - On release, a source already held low is treated as a new edge and is seen 3 edges later.

## Structure
- Package `irq_ctrl_pkg`:
  - Register address constants `REG_STATUS`/`REG_MASK`/`REG_MODE`/`REG_VECTOR`.
  - `VEC_NONE` = 8'h80.
  - `MAX_WIDTH` = 8.
- Sub-module `irq_sync`: one instance per source. Contains the two-flop synchroniser, the previous-value flop and a falling-edge strobe output.
- Top level holds the registers, pending logic, priority encoder and read mux.

## Test plan
- Reset, then read all registers: STATUS/MASK/MODE = 0x00, VECTOR = 0x80, `irq_n` = 1.
- MASK=0x3F, MODE=0x00, drive source 3 low at edge N:
  - `irq_n` = 0 after N+2; VECTOR = 0x03.
  - Release source 3: `irq_n` = 1 two edges later.
- MODE=0x3F, MASK=0x3F, 2-edge low pulse on source 5:
  - STATUS = 0x20 and held.
  - Write STATUS=0x20: STATUS = 0x00 and `irq_n` = 1 after that edge.
- Sources 1 and 4 pending, MASK=0x3F: VECTOR = 0x01. Write MASK=0x3C: VECTOR = 0x04 and `irq_n` stays 0.
- Edge mode: a new falling edge on source 2 coincides with a STATUS write of 0x04. Bit 2 remains set and `irq_n` = 0.
- Assert `reset_n` low asynchronously while `irq_n` = 0: `irq_n` = 1 immediately; MASK reads 0x00 after release.
